// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the issue logic and muldiv_unit.
// Under MULDIV_SIGNED_EN the op field widens to carry the signed operations.
interface muldiv_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 start;
`ifdef MULDIV_SIGNED_EN
    logic [2:0]           op;
`else
    logic [1:0]           op;
`endif
    logic [BUS_WIDTH-1:0] operandA;
    logic [BUS_WIDTH-1:0] operandB;
    logic [4:0]           destReg;
    logic                 busy;
    logic                 done;
    logic [BUS_WIDTH-1:0] result;
    logic [4:0]           writeReg;
    logic                 write;

    modport master (
        output start, op, operandA, operandB, destReg,
        input  busy, done, result, writeReg, write
    );

    modport slave (
        input  start, op, operandA, operandB, destReg,
        output busy, done, result, writeReg, write
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32 multiply/divide, one bit per clock.
// Define MULDIV_SIGNED_EN to add MULH/MULHSU/DIV/REM via sign-magnitude wrapping.
module muldiv_unit #(
    parameter int BUS_WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int W  = BUS_WIDTH;
    localparam int CW = $clog2(W);
`ifdef MULDIV_SIGNED_EN
    localparam int OPW = 3;
`else
    localparam int OPW = 2;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [OPW-1:0] op_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [CW-1:0]  cnt;
    logic           is_div;
    logic           hi_sel;
    logic [W:0]     sum;
    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic [W-1:0]   hi_n;
    logic [W-1:0]   lo_n;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;
    logic [W-1:0]   res_n;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
`ifdef MULDIV_SIGNED_EN
    logic           sa;
    logic           sb;
    logic           neg_q;
    logic           neg_r;
    logic           neg_q_in;
    logic           neg_r_in;
`endif

    assign is_div = op_q[1];

    // Operand conditioning at accept: magnitudes plus result-sign flags.
    always_comb begin
        a_mag = bus.operandA;
        b_mag = bus.operandB;
`ifdef MULDIV_SIGNED_EN
        sa = bus.op[2] & bus.operandA[W-1];
        sb = bus.op[2] & (bus.op[1:0] != 2'b01) & bus.operandB[W-1];
        if (sa) a_mag = -bus.operandA;
        if (sb) b_mag = -bus.operandB;
        neg_q_in = sa ^ sb;
        if (bus.op[1] && bus.operandB == '0) neg_q_in = 1'b0;
        neg_r_in = sa & bus.op[1];
`endif
    end

    // hi:lo is the product (mul) or remainder:quotient (div).
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        shifted = {hi, lo[W-1]};
        diff    = shifted - {1'b0, b_q};
        if (is_div) begin
            if (!diff[W]) begin
                hi_n = diff[W-1:0];
                lo_n = {lo[W-2:0], 1'b1};
            end else begin
                hi_n = shifted[W-1:0];
                lo_n = {lo[W-2:0], 1'b0};
            end
        end else begin
            hi_n = sum[W:1];
            lo_n = {sum[0], lo[W-1:1]};
        end
    end

    always_comb begin
        res_hi = hi_n;
        res_lo = lo_n;
`ifdef MULDIV_SIGNED_EN
        if (is_div) begin
            if (neg_q) res_lo = -lo_n;
            if (neg_r) res_hi = -hi_n;
        end else if (neg_q) begin
            {res_hi, res_lo} = -{hi_n, lo_n};
        end
        hi_sel = op_q[1] ? op_q[0] : (op_q[0] | op_q[2]);
`else
        hi_sel = op_q[0];
`endif
        res_n = hi_sel ? res_hi : res_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= '0;
            b_q          <= '0;
            hi           <= '0;
            lo           <= '0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.write    <= 1'b0;
            bus.result   <= '0;
            bus.writeReg <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= RUN;
                        op_q         <= bus.op;
                        b_q          <= b_mag;
                        hi           <= '0;
                        lo           <= a_mag;
                        cnt          <= '0;
                        bus.writeReg <= bus.destReg;
                        bus.busy     <= 1'b1;
`ifdef MULDIV_SIGNED_EN
                        neg_q        <= neg_q_in;
                        neg_r        <= neg_r_in;
`endif
                    end
                end
                RUN: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state      <= DONE;
                        bus.result <= res_n;
                        bus.done   <= 1'b1;
                        bus.write  <= (bus.writeReg != 5'd0);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                    bus.write <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus reset, back-to-back and random
// sequences for muldiv_unit; honours MULDIV_SIGNED_EN.
module tb_muldiv_unit;
`ifdef MULDIV_SIGNED_EN
    localparam int OPW  = 3;
    localparam int NOPS = 8;
`else
    localparam int OPW  = 2;
    localparam int NOPS = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_if #(.BUS_WIDTH(32)) bus ();

    muldiv_unit #(.BUS_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint      sp;
        p  = {32'b0, a} * {32'b0, b};
        sp = 0;
        case (op)
            3'd0: return p[31:0];
            3'd1: return p[63:32];
            3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd3: return (b == 0) ? a : a % b;
`ifdef MULDIV_SIGNED_EN
            3'd4: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp[63:32];
            end
            3'd5: begin
                sp = longint'($signed(a)) * longint'({32'b0, b});
                return sp[63:32];
            end
            3'd6: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd7: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h0;
                return $signed(a) % $signed(b);
            end
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp, input string nm);
        int n;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op[OPW-1:0];
        bus.operandA = a;
        bus.operandB = b;
        bus.destReg  = d;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.op       = OPW'($urandom);
        bus.operandA = $urandom;
        bus.operandB = $urandom;
        bus.destReg  = 5'($urandom);
        chk({nm, " busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 100) begin
            chk({nm, " write_idle"}, 32'(bus.write), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd32);
        chk({nm, " result"}, bus.result, exp);
        chk({nm, " write"}, 32'(bus.write), 32'(d != 5'd0));
        chk({nm, " writeReg"}, 32'(bus.writeReg), 32'(d));
        @(posedge clk);
        #1;
        chk({nm, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({nm, " write_pulse"}, 32'(bus.write), 32'd0);
        chk({nm, " busy_end"}, 32'(bus.busy), 32'd0);
        chk({nm, " result_hold"}, bus.result, exp);
    endtask

    initial begin
        int          last;
        int          seen;
        int          ev;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'h2, 5'd5, 32'hFFFF_FFFE, "mul_ff_x2"});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, "mulhu_ff"});
        vecs.push_back('{3'd0, 32'd7, 32'd6, 5'd0, 32'd42, "mul_7x6_r0"});
        vecs.push_back('{3'd0, 32'h1234_5678, 32'h10, 5'd1, 32'h2345_6780, "mul_shift"});
        vecs.push_back('{3'd1, 32'h0001_0000, 32'h0001_0000, 5'd2, 32'h1, "mulhu_2p32"});
        vecs.push_back('{3'd2, 32'd100, 32'd7, 5'd3, 32'd14, "divu_100_7"});
        vecs.push_back('{3'd3, 32'd100, 32'd7, 5'd4, 32'd2, "remu_100_7"});
        vecs.push_back('{3'd2, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, "divu_by0"});
        vecs.push_back('{3'd3, 32'd5, 32'd0, 5'd8, 32'd5, "remu_by0"});
        vecs.push_back('{3'd2, 32'd3, 32'd9, 5'd9, 32'd0, "divu_small"});
        vecs.push_back('{3'd3, 32'd3, 32'd9, 5'd31, 32'd3, "remu_small"});
`ifdef MULDIV_SIGNED_EN
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, "div_ovf"});
        vecs.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0, "rem_ovf"});
        vecs.push_back('{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0, "mulh_m1"});
        vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFF, "mulhsu_m1"});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFD, "div_m7_2"});
        vecs.push_back('{3'd7, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFF, "rem_m7_2"});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0, 5'd16, 32'hFFFF_FFFF, "div_by0"});
        vecs.push_back('{3'd7, 32'hFFFF_FFF9, 32'd0, 5'd17, 32'hFFFF_FFF9, "rem_by0"});
`endif

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = '0;
        bus.operandA = '0;
        bus.operandB = '0;
        bus.destReg  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst write", 32'(bus.write), 32'd0);
        chk("rst result", bus.result, 32'd0);
        chk("rst writeReg", 32'(bus.writeReg), 32'd0);
        rst = 1'b0;

        // Abort a MUL partway through RUN.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = '0;
        bus.operandA = 32'd7;
        bus.operandB = 32'd6;
        bus.destReg  = 5'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        ev = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.write) ev++;
        end
        chk("abort no_done", 32'(ev), 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d,
                   vecs[i].exp, vecs[i].nm);

        // start held high: one op every 34 clocks, never a write to x0.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = '0;
        bus.operandA = 32'd3;
        bus.operandB = 32'd5;
        bus.destReg  = 5'd0;
        last = -1;
        seen = 0;
        for (int c = 0; c < 150 && seen < 3; c++) begin
            @(posedge clk);
            #1;
            chk("b2b write", 32'(bus.write), 32'd0);
            if (bus.done) begin
                chk("b2b result", bus.result, 32'd15);
                if (last >= 0) chk("b2b interval", 32'(c - last), 32'd34);
                last = c;
                seen++;
            end
        end
        bus.start = 1'b0;
        chk("b2b done_count", 32'(seen), 32'd3);
        @(posedge clk);
        #1;
        chk("b2b idle", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, NOPS - 1));
            ra  = $urandom;
            if (i % 10 == 0) rb = 32'd0;
            else if (i % 3 == 0) rb = $urandom_range(1, 100);
            else rb = $urandom;
            if (i % 7 == 0) ra = $urandom_range(0, 50);
            run_op(rop, ra, rb, 5'($urandom_range(0, 31)),
                   model(rop, ra, rb), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
